uart_rx_fifo: RTL and testbench

- UART receive front-end for the pipelined CPU's peripheral space. It samples the board uart_rx pin, deserialises 8N1 frames and buffers the bytes in a small first-word-fall-through FIFO.
- The MEM-stage peripheral decoder pops bytes through rd_en/rd_data.
- irq feeds the CPU interrupt request path, so the Hazard unit sees it through irqout.
- Sits between the board pin and the MEM-stage peripheral bus.

---
 rtl/uart_rx_fifo.sv | 212 +++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with a first-word-fall-through byte FIFO and sticky error flags.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_rx_fifo #(
    parameter int BIT_DIV = 10417,
    parameter int FIFO_AW = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             uart_rx,
    input  logic             rd_en,
    input  logic             err_clr,
    output logic [7:0]       rd_data,
    output logic             rx_valid,
    output logic [FIFO_AW:0] rx_count,
    output logic             frame_err,
    output logic             overrun,
    output logic             parity_err,
    output logic             irq
);

    localparam int CW = $clog2(BIT_DIV);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [CW-1:0] HALF = CW'(BIT_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(BIT_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE = 1;
    localparam logic [FIFO_AW-1:0] PTR_ONE = 1;
    localparam logic [FIFO_AW:0] COUNT_ONE = 1;
    localparam logic [FIFO_AW:0] COUNT_FULL = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BRK
    } state_t;

    state_t              state_q, state_d;
    logic                sync1_q, sync2_q;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          idx_q, idx_d;
    logic [7:0]          shift_q, shift_d;
    logic                push_q, push_d;
    logic                frame_set;
    logic [7:0]          mem_q [DEPTH];
    logic [FIFO_AW-1:0]  wptr_q, rptr_q;
    logic [FIFO_AW:0]    count_q, count_d;
    logic                rx_valid_q, irq_q, frame_err_q, overrun_q;
    logic                rxs, full, do_pop, push_ok, ovr_set;
`ifdef UART_RX_PARITY_EN
    logic                par_set;
    logic                parity_err_q;
`endif

    assign rxs = sync2_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            push_q  <= 1'b0;
        end else begin
            sync1_q <= uart_rx;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            push_q  <= push_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        push_d    = 1'b0;
        frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_set   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (!rxs) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rxs ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DATA: begin
                if (cnt_q == FULL) begin
                    shift_d[idx_q] = rxs;
                    cnt_d          = '0;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == FULL) begin
                    par_set = (^shift_q) ^ rxs;
                    cnt_d   = '0;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == FULL) begin
                    cnt_d = '0;
                    if (rxs) begin
                        push_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_d   = S_BRK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            // Held-low line must return high before another start can be recognised.
            S_BRK: begin
                if (rxs) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign full    = (count_q == COUNT_FULL);
    assign do_pop  = rd_en && (count_q != '0);
    assign push_ok = push_q && (!full || do_pop);
    assign ovr_set = push_q && full && !do_pop;

    always_comb begin
        count_d = count_q;
        if (push_ok && !do_pop)      count_d = count_q + COUNT_ONE;
        else if (!push_ok && do_pop) count_d = count_q - COUNT_ONE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            rx_valid_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wptr_q] <= shift_q;
                wptr_q        <= wptr_q + PTR_ONE;
            end
            if (do_pop) rptr_q <= rptr_q + PTR_ONE;
            count_q    <= count_d;
            rx_valid_q <= (count_d != '0);
            irq_q      <= (count_d != '0);
        end
    end

    // Set events take priority over a same-cycle clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= frame_set | (frame_err_q & ~err_clr);
            overrun_q   <= ovr_set | (overrun_q & ~err_clr);
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) parity_err_q <= 1'b0;
        else        parity_err_q <= par_set | (parity_err_q & ~err_clr);
    end
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign rd_data   = mem_q[rptr_q];
    assign rx_valid  = rx_valid_q;
    assign rx_count  = count_q;
    assign irq       = irq_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed testbench for uart_rx_fifo with BIT_DIV=16; parity scenario runs when UART_RX_PARITY_EN is defined.
module tb_uart_rx_fifo;

    localparam int BD = 16;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int PUSH_CYC = FRAME_BITS * BD - 5;
    localparam int FRAME_CYC = FRAME_BITS * BD;

    logic       clk;
    logic       reset;
    logic       uart_rx;
    logic       rd_en;
    logic       err_clr;
    logic [7:0] rd_data;
    logic       rx_valid;
    logic [2:0] rx_count;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;
    logic       irq;

    int checks = 0;
    int errors = 0;

    uart_rx_fifo #(.BIT_DIV(BD), .FIFO_AW(2)) dut (
        .clk(clk), .reset(reset), .uart_rx(uart_rx), .rd_en(rd_en), .err_clr(err_clr),
        .rd_data(rd_data), .rx_valid(rx_valid), .rx_count(rx_count), .frame_err(frame_err),
        .overrun(overrun), .parity_err(parity_err), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives ncyc cycles of a frame; rd_en is high for the cycle ending at edge popAt+1.
    task automatic drive_frame(input logic [7:0] data, input logic stopBit, input logic parBit,
                               input int popAt, input int ncyc);
        logic [10:0] frm;
        frm = {1'b1, stopBit, data, 1'b0};
`ifdef UART_RX_PARITY_EN
        frm = {stopBit, parBit, data, 1'b0};
`endif
        for (int c = 0; c < ncyc; c++) begin
            uart_rx = frm[c / BD];
            rd_en   = (c == popAt);
            tick(1);
        end
        rd_en = 1'b0;
    endtask

    task automatic send(input logic [7:0] data);
        drive_frame(data, 1'b1, ^data, -1, FRAME_CYC);
        uart_rx = 1'b1;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; uart_rx = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
        tick(3);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rx_valid got %b expected 0", rx_valid); end
        checks++; if (rx_count !== 3'd0) begin errors++; $display("[TB] FAIL reset_rx_count got %0d expected 0", rx_count); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_rd_data got %h expected 00", rd_data); end
        checks++; if ({irq, frame_err, overrun, parity_err} !== 4'b0) begin errors++; $display("[TB] FAIL reset_flags got %b expected 0000", {irq, frame_err, overrun, parity_err}); end
        reset = 1'b1;
        tick(4);
    endtask

    task automatic test_single();
        send(8'h55);
        tick(2 * BD);
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_rx_valid got %b expected 1", rx_valid); end
        checks++; if (rd_data !== 8'h55) begin errors++; $display("[TB] FAIL single_rd_data got %h expected 55", rd_data); end
        checks++; if (rx_count !== 3'd1) begin errors++; $display("[TB] FAIL single_rx_count got %0d expected 1", rx_count); end
        checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL single_irq got %b expected 1", irq); end
        checks++; if ({frame_err, overrun, parity_err} !== 3'b0) begin errors++; $display("[TB] FAIL single_flags got %b expected 000", {frame_err, overrun, parity_err}); end
        pop();
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_pop_valid got %b expected 0", rx_valid); end
        checks++; if (rx_count !== 3'd0) begin errors++; $display("[TB] FAIL single_pop_count got %0d expected 0", rx_count); end
        checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL single_pop_irq got %b expected 0", irq); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [4];
        exp = '{8'h01, 8'h80, 8'hFF, 8'hA5};
        for (int i = 0; i < 4; i++) send(exp[i]);
        tick(2 * BD);
        checks++; if (rx_count !== 3'd4) begin errors++; $display("[TB] FAIL b2b_count got %0d expected 4", rx_count); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (rd_data !== exp[i]) begin errors++; $display("[TB] FAIL b2b_pop%0d got %h expected %h", i, rd_data, exp[i]); end
            pop();
        end
        checks++; if (rx_count !== 3'd0) begin errors++; $display("[TB] FAIL b2b_empty_count got %0d expected 0", rx_count); end
        pop();
        checks++; if (rx_count !== 3'd0 || rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_underflow got count %0d valid %b expected 0 0", rx_count, rx_valid); end
    endtask

    task automatic test_overrun();
        logic [7:0] exp [4];
        exp = '{8'h80, 8'hFF, 8'hA5, 8'h3C};
        send(8'h01); send(8'h80); send(8'hFF); send(8'hA5); send(8'h3C);
        tick(2 * BD);
        checks++; if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL ovr_flag got %b expected 1", overrun); end
        checks++; if (rx_count !== 3'd4) begin errors++; $display("[TB] FAIL ovr_count got %0d expected 4", rx_count); end
        checks++; if (rd_data !== 8'h01) begin errors++; $display("[TB] FAIL ovr_head got %h expected 01", rd_data); end
        clear_errors();
        checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL ovr_clear got %b expected 0", overrun); end
        drive_frame(8'h3C, 1'b1, ^8'h3C, PUSH_CYC, FRAME_CYC);
        uart_rx = 1'b1;
        tick(2 * BD);
        checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL ovr_pop_flag got %b expected 0", overrun); end
        checks++; if (rx_count !== 3'd4) begin errors++; $display("[TB] FAIL ovr_pop_count got %0d expected 4", rx_count); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (rd_data !== exp[i]) begin errors++; $display("[TB] FAIL ovr_drain%0d got %h expected %h", i, rd_data, exp[i]); end
            pop();
        end
    endtask

    task automatic test_frame_error();
        drive_frame(8'h77, 1'b0, ^8'h77, -1, FRAME_CYC);
        uart_rx = 1'b0;
        tick(40);
        uart_rx = 1'b1;
        tick(13 * BD);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("[TB] FAIL ferr_flag got %b expected 1", frame_err); end
        checks++; if (rx_count !== 3'd0) begin errors++; $display("[TB] FAIL ferr_count got %0d expected 0", rx_count); end
        clear_errors();
        checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL ferr_clear got %b expected 0", frame_err); end
    endtask

    task automatic test_glitch();
        uart_rx = 1'b0;
        tick(5);
        uart_rx = 1'b1;
        tick(13 * BD);
        checks++; if (rx_count !== 3'd0 || rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL glitch got count %0d valid %b expected 0 0", rx_count, rx_valid); end
    endtask

    task automatic test_reset_mid_frame();
        send(8'h99);
        tick(2 * BD);
        drive_frame(8'h34, 1'b1, ^8'h34, -1, 60);
        reset = 1'b0;
        #1;
        checks++; if (rx_count !== 3'd0 || rx_valid !== 1'b0 || irq !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_outputs got count %0d valid %b irq %b expected 0 0 0", rx_count, rx_valid, irq); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("[TB] FAIL rstmid_rd_data got %h expected 00", rd_data); end
        tick(2);
        reset = 1'b1;
        uart_rx = 1'b1;
        tick(3 * BD);
        send(8'h12);
        tick(2 * BD);
        checks++; if (rx_count !== 3'd1) begin errors++; $display("[TB] FAIL rstmid_count got %0d expected 1", rx_count); end
        checks++; if (rd_data !== 8'h12) begin errors++; $display("[TB] FAIL rstmid_data got %h expected 12", rd_data); end
        pop();
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        drive_frame(8'h03, 1'b1, 1'b1, -1, FRAME_CYC);
        uart_rx = 1'b1;
        tick(2 * BD);
        checks++; if (parity_err !== 1'b1) begin errors++; $display("[TB] FAIL par_bad_flag got %b expected 1", parity_err); end
        checks++; if (rx_count !== 3'd1 || rd_data !== 8'h03) begin errors++; $display("[TB] FAIL par_bad_push got count %0d data %h expected 1 03", rx_count, rd_data); end
        pop();
        clear_errors();
        drive_frame(8'h03, 1'b1, 1'b0, -1, FRAME_CYC);
        uart_rx = 1'b1;
        tick(2 * BD);
        checks++; if (parity_err !== 1'b0) begin errors++; $display("[TB] FAIL par_good_flag got %b expected 0", parity_err); end
        checks++; if (rx_count !== 3'd1 || rd_data !== 8'h03) begin errors++; $display("[TB] FAIL par_good_push got count %0d data %h expected 1 03", rx_count, rd_data); end
        pop();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_frame_error();
        test_glitch();
        test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
